// File: rtl/branch_cmp_unit.sv
// rtl/branch_cmp_unit.sv - eight-mode branch condition compare with operand wait and perf counters
//
// Purpose:
//   Decode-stage branch condition unit. A request is accepted over in_valid/in_ready.
//   If its forwarded operands are already final, the result is registered at once.
//   Otherwise the unit parks in WAIT until the operands are marked ready.
//   The taken/not-taken result is then offered over out_valid/out_ready.
//   Two saturating counters trace delivered taken branches and cycles spent waiting.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             synchronous kill of any in-flight request
//   in_valid/in_ready request handshake; op sampled at accept
//   op                compare mode (EQ NE LEZ GTZ LTZ GEZ LT LTU)
//   a, b              forwarded operands; a_rdy/b_rdy mark them final
//   out_valid/out_ready result handshake
//   taken             registered branch condition, stable while out_valid
//   taken_cnt         delivered results with taken=1 (saturating)
//   wait_cnt          cycles spent in WAIT (saturating)

module branch_cmp_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_rdy,
  input  logic             b_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [2:0] op_q;
  logic       taken_q;

  logic       accept;
  logic       handshake;
  logic       ops_ok_in;
  logic       ops_ok_wait;
  logic       load;
  logic [2:0] load_op;

  // Zero-compare modes (LEZ, GTZ, LTZ, GEZ) only look at a.
  function automatic logic uses_b(input logic [2:0] m);
    return !((m == 3'd2) || (m == 3'd3) || (m == 3'd4) || (m == 3'd5));
  endfunction

  function automatic logic compare(input logic [2:0] m,
                                   input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
    logic res;
    res = 1'b0;
    case (m)
      3'd0: res = (x == y);
      3'd1: res = (x != y);
      3'd2: res = x[WIDTH-1] || (x == '0);
      3'd3: res = !x[WIDTH-1] && (x != '0);
      3'd4: res = x[WIDTH-1];
      3'd5: res = !x[WIDTH-1];
      3'd6: res = ($signed(x) < $signed(y));
      3'd7: res = (x < y);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign out_valid = (state == S_DONE);
  assign taken     = taken_q;
  assign in_ready  = !flush && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Incoming requests are judged by their own op; a parked request by the stored op.
  assign ops_ok_in   = a_rdy && (b_rdy || !uses_b(op));
  assign ops_ok_wait = a_rdy && (b_rdy || !uses_b(op_q));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_op  = op;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (ops_ok_in) begin
              load     = 1'b1;
              state_nx = S_DONE;
            end else begin
              state_nx = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (ops_ok_wait) begin
            load     = 1'b1;
            load_op  = op_q;
            state_nx = S_DONE;
          end
        end
        S_DONE: begin
          // A new request can only be accepted here in the handshake cycle.
          if (accept) begin
            if (ops_ok_in) begin
              load     = 1'b1;
              state_nx = S_DONE;
            end else begin
              state_nx = S_WAIT;
            end
          end else if (out_ready) begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= 3'd0;
      taken_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= op;
      end
      if (load) begin
        taken_q <= compare(load_op, a, b);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt <= '0;
      wait_cnt  <= '0;
    end else if (!flush) begin
      if (handshake && taken_q && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
      if ((state == S_WAIT) && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_cmp_unit.sv
// tb/tb_branch_cmp_unit.sv - scoreboard bench for branch_cmp_unit

module tb_branch_cmp_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        a_rdy;
  logic        b_rdy;
  logic        out_ready;

  logic        in_ready, out_valid, taken;
  logic [15:0] taken_cnt, wait_cnt;
  logic        in_ready_s, out_valid_s, taken_s;
  logic [1:0]  taken_cnt_s, wait_cnt_s;

  int   total;
  int   bad;
  logic sb_q[$];
  logic exp_t;

  branch_cmp_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .a_rdy(a_rdy), .b_rdy(b_rdy), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .taken_cnt(taken_cnt), .wait_cnt(wait_cnt)
  );

  branch_cmp_unit #(.WIDTH(32), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b), .a_rdy(a_rdy), .b_rdy(b_rdy), .out_valid(out_valid_s),
    .out_ready(out_ready), .taken(taken_s), .taken_cnt(taken_cnt_s), .wait_cnt(wait_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle request with out_ready held high: result the next cycle, delivered after.
  task automatic issue(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y,
                       input logic exp);
    op = m; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
  endtask

  // Monitor: every presented handshake pops one expected result.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: result %0b with nothing expected at %0t", taken, $time);
      end else begin
        exp_t = sb_q.pop_front();
        chk("sb_taken", {31'd0, taken}, {31'd0, exp_t});
        chk("sb_taken_sat_dut", {31'd0, taken_s}, {31'd0, exp_t});
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
    a_rdy = 1'b1; b_rdy = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("rst_wait_cnt", {16'd0, wait_cnt}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // EQ immediate
    issue(3'd0, 32'h1234, 32'h1234, 1'b1);
    chk("eq_taken_cnt", {16'd0, taken_cnt}, 32'd1);
    chk("eq_back_idle", {31'd0, out_valid}, 32'd0);

    // Sign modes and signed/unsigned less-than
    issue(3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(3'd4, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(3'd1, 32'd5, 32'd6, 1'b1);
    b_rdy = 1'b0;                             // zero-compare modes ignore b_rdy
    issue(3'd3, 32'd5, 32'd0, 1'b1);
    issue(3'd2, 32'd0, 32'd0, 1'b1);
    b_rdy = 1'b1;
    issue(3'd6, 32'd1, 32'hFFFF_FFFF, 1'b0);
    issue(3'd7, 32'd1, 32'hFFFF_FFFF, 1'b1);
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    chk("mix_taken_cnt", {16'd0, taken_cnt}, 32'd8);
    chk("sat_taken_cnt", {30'd0, taken_cnt_s}, 32'd3);

    // Operand wait: a changes while not ready, only the ready value is used
    out_ready = 1'b0;
    op = 3'd1; a = 32'd5; a_rdy = 1'b0; b = 32'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
    chk("wait_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    a = 32'd6; tick();
    a = 32'd7; tick();
    a = 32'd9; a_rdy = 1'b1;
    sb_q.push_back(1'b0);
    tick();
    chk("wait_done_valid", {31'd0, out_valid}, 32'd1);
    chk("wait_cnt", {16'd0, wait_cnt}, 32'd4);
    chk("wait_cnt_sat", {30'd0, wait_cnt_s}, 32'd3);

    // Backpressure: result held, no new request accepted
    for (int i = 0; i < 4; i++) begin
      a = 32'd100 + i;
      tick();
      chk("bp_taken", {31'd0, taken}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    // Back-to-back: handshake and new ready EQ request in the same cycle
    out_ready = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7; in_valid = 1'b1;
    sb_q.push_back(1'b1);
    tick();
    in_valid = 1'b0;
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_taken", {31'd0, taken}, 32'd1);
    tick();
    chk("b2b_idle", {31'd0, out_valid}, 32'd0);
    chk("b2b_taken_cnt", {16'd0, taken_cnt}, 32'd9);

    // Flush in WAIT
    op = 3'd0; a = 32'd1; b = 32'd1; b_rdy = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; b_rdy = 1'b1;
    chk("flush_wait_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_wait_cnt", {16'd0, wait_cnt}, 32'd5);
    #1;
    chk("flush_idle_ready", {31'd0, in_ready}, 32'd1);

    // Flush in DONE with out_ready high: handshake not counted
    out_ready = 1'b0; op = 3'd0; a = 32'd2; b = 32'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    sb_q.push_back(1'b1);
    tick();
    flush = 1'b0;
    chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_done_taken_cnt", {16'd0, taken_cnt}, 32'd9);

    // Asynchronous reset mid-WAIT
    op = 3'd0; a = 32'd1; b = 32'd1; b_rdy = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_taken", {31'd0, taken}, 32'd0);
    chk("arst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("arst_wait_cnt", {16'd0, wait_cnt}, 32'd0);
    chk("arst_sat_taken_cnt", {30'd0, taken_cnt_s}, 32'd0);
    tick();
    reset = 1'b0; b_rdy = 1'b1;
    tick();
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_no_result", {31'd0, out_valid}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
